// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: FSM states, ExcCodes,
// slot cause-bit indices and the interrupt-pending helper.
package exc_ctrl_pkg;

  typedef enum logic [1:0] {
    EXC_IDLE     = 2'd0,
    EXC_FLUSH    = 2'd1,
    EXC_REDIRECT = 2'd2
  } exc_state_e;

  localparam logic [4:0] EXCEPTION_INT  = 5'h00;
  localparam logic [4:0] EXCEPTION_ADEL = 5'h04;
  localparam logic [4:0] EXCEPTION_ADES = 5'h05;
  localparam logic [4:0] EXCEPTION_SYS  = 5'h08;
  localparam logic [4:0] EXCEPTION_BP   = 5'h09;
  localparam logic [4:0] EXCEPTION_RI   = 5'h0a;
  localparam logic [4:0] EXCEPTION_OV   = 5'h0c;
  localparam logic [4:0] EXCEPTION_TR   = 5'h0d;
  localparam logic [4:0] EXC_ERET       = 5'h0e;

  // Bit positions inside the 8-bit per-slot cause vector.
  localparam int CB_ERET    = 7;
  localparam int CB_IF_ADEL = 6;
  localparam int CB_RI      = 5;
  localparam int CB_OV      = 4;
  localparam int CB_TR      = 3;
  localparam int CB_SYS     = 2;
  localparam int CB_BP      = 1;
  localparam int CB_MEM     = 0;

  // Unmasked interrupt, interrupts globally enabled, not already at exception level.
  function automatic logic int_pending(input logic [31:0] status, input logic [31:0] cause);
    return (|(cause[15:8] & status[15:8])) & status[0] & ~status[1];
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Per-slot priority encoder: reduces one slot's cause bits (plus an optional
// interrupt request) to a single event flag and ExcCode. Purely combinational.
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic [7:0] exc_i,
  input  logic       store_i,
  input  logic       int_i,
  output logic       evt_o,
  output logic [4:0] type_o
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    evt_o  = int_i | (|exc_i);
    type_o = EXCEPTION_INT;
    if (int_i)                  type_o = EXCEPTION_INT;
    else if (exc_i[CB_IF_ADEL]) type_o = EXCEPTION_ADEL;
    else if (exc_i[CB_RI])      type_o = EXCEPTION_RI;
    else if (exc_i[CB_OV])      type_o = EXCEPTION_OV;
    else if (exc_i[CB_TR])      type_o = EXCEPTION_TR;
    else if (exc_i[CB_SYS])     type_o = EXCEPTION_SYS;
    else if (exc_i[CB_BP])      type_o = EXCEPTION_BP;
    else if (exc_i[CB_MEM])     type_o = store_i ? EXCEPTION_ADES : EXCEPTION_ADEL;
    else if (exc_i[CB_ERET])    type_o = EXC_ERET;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: commit strobe to cp0, pipeline flush, then redirect.
// Optional macro EXC_PERF_CNT_EN adds exception/interrupt event counters.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_OFFSET   = 32'h180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid_i,
  input  logic        slot1_valid_i,
  input  logic        slot2_valid_i,
  input  logic [7:0]  slot1_exc_i,
  input  logic [7:0]  slot2_exc_i,
  input  logic        slot1_store_i,
  input  logic        slot2_store_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] ebase_i,
  output logic        exception_flag_o,
  output logic [4:0]  exception_type_o,
  output logic        exception_first_inst_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
`ifdef EXC_PERF_CNT_EN
  output logic [31:0] exc_count_o,
  output logic [31:0] int_count_o,
`endif
  output logic        busy_o
);

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  exc_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;

  logic       s1_act, s2_act, int_pend;
  logic       s1_evt, s2_evt, take;
  logic [4:0] s1_type, s2_type, sel_type;

  assign int_pend = int_pending(status_i, cause_i);
  assign s1_act   = commit_valid_i & slot1_valid_i;
  assign s2_act   = commit_valid_i & slot2_valid_i;

  exc_prio_enc u_slot1 (
    .exc_i   (s1_act ? slot1_exc_i : 8'h00),
    .store_i (slot1_store_i),
    .int_i   (s1_act & int_pend),
    .evt_o   (s1_evt),
    .type_o  (s1_type)
  );

  exc_prio_enc u_slot2 (
    .exc_i   (s2_act ? slot2_exc_i : 8'h00),
    .store_i (slot2_store_i),
    .int_i   (1'b0),
    .evt_o   (s2_evt),
    .type_o  (s2_type)
  );

  // Slot1 is older, so any slot1 event masks slot2 entirely.
  assign sel_type = s1_evt ? s1_type : s2_type;
  assign take     = (state_q == EXC_IDLE) & ~rst & (s1_evt | s2_evt);

  assign exception_flag_o       = take;
  assign exception_type_o       = take ? sel_type : 5'h00;
  assign exception_first_inst_o = take & s1_evt;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      EXC_IDLE: begin
        if (take) begin
          state_d  = EXC_FLUSH;
          cnt_d    = 4'd0;
          target_d = (sel_type == EXC_ERET) ? epc_i : ebase_i + EXC_OFFSET;
        end
      end
      EXC_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = EXC_REDIRECT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      EXC_REDIRECT: begin
        if (redirect_ready_i) state_d = EXC_IDLE;
      end
      default: state_d = EXC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EXC_IDLE;
      cnt_q    <= 4'd0;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  assign flush_o          = (state_q == EXC_FLUSH);
  assign redirect_valid_o = (state_q == EXC_REDIRECT);
  assign redirect_pc_o    = redirect_valid_o ? target_q : 32'h0;
  assign busy_o           = (state_q != EXC_IDLE);

`ifdef EXC_PERF_CNT_EN
  logic [31:0] exc_cnt_q, int_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_cnt_q <= 32'h0;
      int_cnt_q <= 32'h0;
    end else if (take) begin
      if (sel_type != EXC_ERET)      exc_cnt_q <= exc_cnt_q + 32'd1;
      if (sel_type == EXCEPTION_INT) int_cnt_q <= int_cnt_q + 32'd1;
    end
  end

  assign exc_count_o = exc_cnt_q;
  assign int_count_o = int_cnt_q;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes expected commits/redirects,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_exc_ctrl;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid_i, slot1_valid_i, slot2_valid_i;
  logic [7:0]  slot1_exc_i, slot2_exc_i;
  logic        slot1_store_i, slot2_store_i;
  logic [31:0] status_i, cause_i, epc_i, ebase_i;
  logic        exception_flag_o, exception_first_inst_o;
  logic [4:0]  exception_type_o;
  logic        flush_o, redirect_valid_o, redirect_ready_i, busy_o;
  logic [31:0] redirect_pc_o;

  exc_ctrl #(.FLUSH_CYCLES(FLUSH), .EXC_OFFSET(32'h180)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .commit_valid_i         (commit_valid_i),
    .slot1_valid_i          (slot1_valid_i),
    .slot2_valid_i          (slot2_valid_i),
    .slot1_exc_i            (slot1_exc_i),
    .slot2_exc_i            (slot2_exc_i),
    .slot1_store_i          (slot1_store_i),
    .slot2_store_i          (slot2_store_i),
    .status_i               (status_i),
    .cause_i                (cause_i),
    .epc_i                  (epc_i),
    .ebase_i                (ebase_i),
    .exception_flag_o       (exception_flag_o),
    .exception_type_o       (exception_type_o),
    .exception_first_inst_o (exception_first_inst_o),
    .flush_o                (flush_o),
    .redirect_valid_o       (redirect_valid_o),
    .redirect_pc_o          (redirect_pc_o),
    .redirect_ready_i       (redirect_ready_i),
    .busy_o                 (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] typ;
    logic       first;
  } flag_exp_t;

  flag_exp_t   flag_q[$];
  logic [31:0] pc_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: commit strobes, flush run lengths, accepted redirects.
  flag_exp_t   mon_e;
  logic [31:0] mon_pc;
  int          flush_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      flush_run = 0;
    end else begin
      if (exception_flag_o) begin
        if (flag_q.size() == 0) begin
          check("spurious_flag", 32'(exception_flag_o), 32'd0);
        end else begin
          mon_e = flag_q.pop_front();
          check("exc_type", 32'(exception_type_o), 32'(mon_e.typ));
          check("first_inst", 32'(exception_first_inst_o), 32'(mon_e.first));
        end
      end
      if (flush_o) flush_run++;
      else if (flush_run != 0) begin
        check("flush_len", 32'(flush_run), 32'(FLUSH));
        flush_run = 0;
      end
      if (redirect_valid_o && redirect_ready_i) begin
        if (pc_q.size() == 0) begin
          check("spurious_redirect", 32'(redirect_valid_o), 32'd0);
        end else begin
          mon_pc = pc_q.pop_front();
          check("redirect_pc", redirect_pc_o, mon_pc);
        end
      end
    end
  end

  task automatic set_in(input logic cv, input logic s1v, input logic s2v,
                        input logic [7:0] e1, input logic [7:0] e2,
                        input logic st1, input logic st2);
    commit_valid_i = cv;
    slot1_valid_i  = s1v;
    slot2_valid_i  = s2v;
    slot1_exc_i    = e1;
    slot2_exc_i    = e2;
    slot1_store_i  = st1;
    slot2_store_i  = st2;
  endtask

  task automatic clear_in();
    set_in(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  // One full exception with fetch always ready; checks redirect latency and busy release.
  task automatic run_exc(input logic s1v, input logic s2v,
                         input logic [7:0] e1, input logic [7:0] e2,
                         input logic st1, input logic st2,
                         input logic [4:0] et, input logic ef, input logic [31:0] pc);
    int lat;
    flag_exp_t e;
    e.typ = et;
    e.first = ef;
    flag_q.push_back(e);
    pc_q.push_back(pc);
    @(posedge clk); #1;
    set_in(1'b1, s1v, s2v, e1, e2, st1, st2);
    @(posedge clk); #1;
    clear_in();
    lat = 1;
    while (!(redirect_valid_o && redirect_ready_i) && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("redirect_latency", 32'(lat), 32'(FLUSH + 1));
    @(posedge clk); #1;
    check("busy_release", 32'(busy_o), 32'd0);
  endtask

  task automatic expect_no_event(input logic cv, input logic s1v, input logic s2v,
                                 input logic [7:0] e1, input logic [7:0] e2);
    @(posedge clk); #1;
    set_in(cv, s1v, s2v, e1, e2, 1'b0, 1'b0);
    #1;
    check("no_flag", 32'(exception_flag_o), 32'd0);
    @(posedge clk); #1;
    clear_in();
    check("no_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    flag_exp_t e;
    int w;
    rst = 1'b1;
    redirect_ready_i = 1'b1;
    status_i = 32'h0;
    cause_i  = 32'h0;
    epc_i    = 32'h0;
    ebase_i  = 32'hBFC00200;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    check("rst_flag", 32'(exception_flag_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_rvalid", 32'(redirect_valid_o), 32'd0);
    check("rst_pc", redirect_pc_o, 32'h0);
    check("rst_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;

    // 1: slot1 overflow -> general vector.
    run_exc(1'b1, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 5'h0c, 1'b1, 32'hBFC00380);
    // 2: slot2 syscall when slot1 clean; slot1 RI beats slot2 syscall.
    run_exc(1'b1, 1'b1, 8'h00, 8'h04, 1'b0, 1'b0, 5'h08, 1'b0, 32'hBFC00380);
    run_exc(1'b1, 1'b1, 8'h20, 8'h04, 1'b0, 1'b0, 5'h0a, 1'b1, 32'hBFC00380);
    // 3: interrupt on IM2, then masked by EXL.
    status_i = 32'h00000401;
    cause_i  = 32'h00000400;
    run_exc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 5'h00, 1'b1, 32'hBFC00380);
    status_i = 32'h00000403;
    expect_no_event(1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    status_i = 32'h0;
    cause_i  = 32'h0;
    // 4: ERET returns to EPC.
    epc_i = 32'h80001234;
    run_exc(1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 5'h0e, 1'b1, 32'h80001234);
    // Within-slot priority and AdEL/AdES selection; invalid slot1 is ignored.
    run_exc(1'b1, 1'b0, 8'h61, 8'h00, 1'b0, 1'b0, 5'h04, 1'b1, 32'hBFC00380);
    run_exc(1'b0, 1'b1, 8'h10, 8'h81, 1'b0, 1'b1, 5'h05, 1'b0, 32'hBFC00380);
    run_exc(1'b1, 1'b0, 8'h03, 8'h00, 1'b1, 1'b0, 5'h09, 1'b1, 32'hBFC00380);
    // Target wraps at 32 bits.
    ebase_i = 32'hFFFFFF00;
    run_exc(1'b1, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 5'h0d, 1'b1, 32'h00000080);
    ebase_i = 32'hBFC00200;
    // commit_valid low masks everything.
    expect_no_event(1'b0, 1'b1, 1'b1, 8'h10, 8'h04);

    // 5: fetch stalls 5 cycles; redirect held; new commit ignored.
    redirect_ready_i = 1'b0;
    e.typ = 5'h0c;
    e.first = 1'b1;
    flag_q.push_back(e);
    pc_q.push_back(32'hBFC00380);
    @(posedge clk); #1;
    set_in(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    clear_in();
    w = 0;
    while (!redirect_valid_o && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("stall_rvalid_seen", 32'(redirect_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_rvalid", 32'(redirect_valid_o), 32'd1);
      check("hold_pc", redirect_pc_o, 32'hBFC00380);
      if (i == 2) begin
        set_in(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        #1;
        check("busy_ignore_flag", 32'(exception_flag_o), 32'd0);
      end else begin
        clear_in();
      end
      @(posedge clk); #1;
    end
    clear_in();
    redirect_ready_i = 1'b1;
    @(posedge clk); #1;
    check("stall_busy_release", 32'(busy_o), 32'd0);

    // 6: reset in FLUSH aborts and drops the redirect.
    e.typ = 5'h0c;
    e.first = 1'b1;
    flag_q.push_back(e);
    @(posedge clk); #1;
    set_in(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    clear_in();
    check("pre_rst_flush", 32'(flush_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_flush", 32'(flush_o), 32'd0);
    check("abort_rvalid", 32'(redirect_valid_o), 32'd0);
    check("abort_pc", redirect_pc_o, 32'h0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_flag", 32'(exception_flag_o), 32'd0);
    rst = 1'b0;
    // Recovery after abort.
    run_exc(1'b1, 1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 5'h08, 1'b1, 32'hBFC00380);

    repeat (2) @(posedge clk);
    #1;
    check("flag_q_drained", 32'(flag_q.size()), 32'd0);
    check("pc_q_drained", 32'(pc_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
